// File: rtl/avoid_obstacle_pkg.sv
// Shared definitions for the ultrasonic obstacle-avoidance blocks.
// Holds the measurement FSM state encoding and the default timing constants
// (50 MHz clk) used by the echo receiver and the trigger generator.
package avoid_obstacle_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARM  = 2'd1,
      ST_MEAS = 2'd2,
      ST_DONE = 2'd3
   } echo_state_t;

   // Echo receiver defaults
   localparam int CLK_PER_CM_DEF = 2900;      // 58 us of echo per cm
   localparam int MAX_CM_DEF     = 400;       // saturation / out-of-range value
   localparam int THRESH_CM_DEF  = 20;        // obstacle when distance below this
   localparam int WAIT_TO_DEF    = 500000;    // 10 ms trig fall -> echo rise
   localparam int MEAS_TO_DEF    = 2000000;   // 40 ms max echo high
   localparam int DW_DEF         = 9;

   // Trigger generator defaults
   localparam int TRIG_PERIOD_DEF = 3000000;  // 60 ms between pings
   localparam int TRIG_PULSE_DEF  = 500;      // 10 us trig high

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer plus one edge flop for an asynchronous input.
// Ports:
//   clk   - system clock
//   rst   - synchronous active-high reset, clears all flops
//   din   - asynchronous input
//   level - synchronized level
//   rise  - one-cycle pulse when level goes 0->1
//   fall  - one-cycle pulse when level goes 1->0
module sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic meta;
   logic prev;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta  <= 1'b0;
         level <= 1'b0;
         prev  <= 1'b0;
      end else begin
         meta  <= din;
         level <= meta;
         prev  <= level;
      end
   end

   assign rise = level & ~prev;
   assign fall = ~level & prev;

endmodule

// File: rtl/avoid_obstacle_echo.sv
// Ultrasonic echo receiver: after each trig pulse, times the echo high
// period and converts it to cm by counting CLK_PER_CM-cycle slices, so no
// divider is needed. Emits a one-cycle strobe with distance, obstacle and
// timeout flags, all held until the next result.
// Ports:
//   clk        - system clock (50 MHz)
//   rst        - synchronous active-high reset
//   trig       - trigger pulse, synchronous to clk
//   echo       - raw sensor echo, asynchronous
//   dist_cm    - last measured distance in cm (MAX_CM on timeout)
//   dist_valid - one-cycle strobe, new result on the outputs
//   obstacle   - last distance below THRESH_CM (never on timeout)
//   timeout    - last measurement had no echo or an over-long echo
//
// state | meaning
// IDLE  | waiting for trig fall, echo ignored
// ARM   | trig seen, waiting for echo rise (bounded by WAIT_TO)
// MEAS  | echo high, counting cm (bounded by MEAS_TO)
// DONE  | one cycle, result latched into the output registers
module avoid_obstacle_echo
   import avoid_obstacle_pkg::*;
#(
   parameter int CLK_PER_CM = CLK_PER_CM_DEF,
   parameter int MAX_CM     = MAX_CM_DEF,
   parameter int THRESH_CM  = THRESH_CM_DEF,
   parameter int WAIT_TO    = WAIT_TO_DEF,
   parameter int MEAS_TO    = MEAS_TO_DEF,
   parameter int DW         = DW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          trig,
   input  logic          echo,
   output logic [DW-1:0] dist_cm,
   output logic          dist_valid,
   output logic          obstacle,
   output logic          timeout
);

   localparam int PRE_W  = $clog2(CLK_PER_CM + 1);
   localparam int WAIT_W = $clog2(WAIT_TO + 1);
   localparam int MEAS_W = $clog2(MEAS_TO + 1);

   echo_state_t state, state_nxt;
   logic        to_flag, to_nxt;
   logic        trig_d, trig_fall;
   logic        echo_level_unused, rise, fall;

   logic [WAIT_W-1:0] wait_cnt;
   logic [MEAS_W-1:0] meas_cnt;
   logic [PRE_W-1:0]  pre_cnt;
   logic [DW-1:0]     cm_cnt;

   sync_edge u_echo_sync (
      .clk   (clk),
      .rst   (rst),
      .din   (echo),
      .level (echo_level_unused),
      .rise  (rise),
      .fall  (fall)
   );

   assign trig_fall = ~trig & trig_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         to_flag <= 1'b0;
      end else begin
         state   <= state_nxt;
         to_flag <= to_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      to_nxt    = to_flag;
      case (state)
         ST_IDLE: if (trig_fall) state_nxt = ST_ARM;
         ST_ARM: begin
            if (rise) begin
               state_nxt = ST_MEAS;
            end else if (wait_cnt == WAIT_W'(WAIT_TO - 1)) begin
               state_nxt = ST_DONE;
               to_nxt    = 1'b1;
            end
         end
         ST_MEAS: begin
            // fall has priority over a coincident measurement timeout
            if (fall) begin
               state_nxt = ST_DONE;
               to_nxt    = 1'b0;
            end else if (meas_cnt == MEAS_W'(MEAS_TO - 1)) begin
               state_nxt = ST_DONE;
               to_nxt    = 1'b1;
            end
         end
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         trig_d     <= 1'b0;
         wait_cnt   <= '0;
         meas_cnt   <= '0;
         pre_cnt    <= '0;
         cm_cnt     <= '0;
         dist_cm    <= '0;
         dist_valid <= 1'b0;
         obstacle   <= 1'b0;
         timeout    <= 1'b0;
      end else begin
         trig_d     <= trig;
         dist_valid <= 1'b0;
         case (state)
            ST_IDLE: if (trig_fall) wait_cnt <= '0;
            ST_ARM: begin
               wait_cnt <= wait_cnt + 1'b1;
               if (rise) begin
                  pre_cnt  <= '0;
                  cm_cnt   <= '0;
                  meas_cnt <= '0;
               end
            end
            ST_MEAS: begin
               // counts through the fall cycle too, so cm_cnt covers every
               // echo-high cycle seen at the synchronizer output
               meas_cnt <= meas_cnt + 1'b1;
               if (pre_cnt == PRE_W'(CLK_PER_CM - 1)) begin
                  pre_cnt <= '0;
                  if (cm_cnt != DW'(MAX_CM)) cm_cnt <= cm_cnt + 1'b1;
               end else begin
                  pre_cnt <= pre_cnt + 1'b1;
               end
            end
            ST_DONE: begin
               dist_cm    <= to_flag ? DW'(MAX_CM) : cm_cnt;
               timeout    <= to_flag;
               obstacle   <= ~to_flag & (cm_cnt < DW'(THRESH_CM));
               dist_valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_avoid_obstacle_echo.sv
module tb_avoid_obstacle_echo;

   localparam int C   = 10;
   localparam int MAX = 400;
   localparam int TH  = 20;
   localparam int WT  = 500;
   localparam int MT  = 4500;
   localparam int DW  = 9;

   logic          clk = 1'b0;
   logic          rst, trig, echo;
   logic [DW-1:0] dist_cm;
   logic          dist_valid, obstacle, timeout;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   int rise_cyc, fall_cyc, arm_edge;

   int q_cm[$];
   int q_ob[$];
   int q_to[$];
   int q_cyc[$];

   avoid_obstacle_echo #(
      .CLK_PER_CM (C),
      .MAX_CM     (MAX),
      .THRESH_CM  (TH),
      .WAIT_TO    (WT),
      .MEAS_TO    (MT),
      .DW         (DW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .trig       (trig),
      .echo       (echo),
      .dist_cm    (dist_cm),
      .dist_valid (dist_valid),
      .obstacle   (obstacle),
      .timeout    (timeout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (dist_valid) begin
         q_cm.push_back(int'(dist_cm));
         q_ob.push_back(int'(obstacle));
         q_to.push_back(int'(timeout));
         q_cyc.push_back(cyc);
      end
   end

   task automatic check_val(input string tag, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_trig();
      arm_edge = cyc + 2;
      trig = 1'b1;
      tick();
      trig = 1'b0;
   endtask

   task automatic echo_pulse(input int n);
      echo = 1'b1;
      rise_cyc = cyc;
      repeat (n) tick();
      echo = 1'b0;
      fall_cyc = cyc;
   endtask

   task automatic pop_result(input string tag, output bit ok,
                             output int cm, output int ob, output int to, output int vc);
      ok = 1'b0; cm = 0; ob = 0; to = 0; vc = 0;
      for (int i = 0; i < WT + MT + 50 && q_cm.size() == 0; i++) tick();
      if (q_cm.size() == 0) begin
         check_val({tag, "_strobe"}, 0, 1);
      end else begin
         ok = 1'b1;
         cm = q_cm.pop_front();
         ob = q_ob.pop_front();
         to = q_to.pop_front();
         vc = q_cyc.pop_front();
      end
   endtask

   // Reference: N echo-high cycles -> min(N / C, MAX); no echo or N > MT is a timeout
   task automatic run_meas(input int dly, input int n, input string tag);
      bit ok;
      int cm, ob, to, vc;
      int e_cm, e_to, e_ob;
      pulse_trig();
      repeat (dly) tick();
      if (n > 0) echo_pulse(n);
      e_to = (n == 0 || n > MT) ? 1 : 0;
      e_cm = e_to ? MAX : ((n / C > MAX) ? MAX : n / C);
      e_ob = (!e_to && e_cm < TH) ? 1 : 0;
      pop_result(tag, ok, cm, ob, to, vc);
      if (ok) begin
         check_val({tag, "_cm"}, cm, e_cm);
         check_val({tag, "_to"}, to, e_to);
         check_val({tag, "_ob"}, ob, e_ob);
         if (n == 0)
            check_val({tag, "_lat_wait"}, vc, arm_edge + WT + 1);
         else if (e_to)
            check_val({tag, "_lat_meas"}, vc, rise_cyc + MT + 4);
         else
            check_val({tag, "_lat_fall"}, vc, fall_cyc + 4);
      end
      repeat (8) tick();
      check_val({tag, "_extra"}, q_cm.size(), 0);
   endtask

   initial begin
      bit ok;
      int cm, ob, to, vc, n, sel;
      rst = 1'b1; trig = 1'b0; echo = 1'b0;
      repeat (3) tick();
      check_val("rst_valid", int'(dist_valid), 0);
      check_val("rst_cm", int'(dist_cm), 0);
      check_val("rst_ob", int'(obstacle), 0);
      check_val("rst_to", int'(timeout), 0);
      rst = 1'b0;
      repeat (3) tick();

      run_meas(100, 10 * C, "cm10");
      run_meas(100, 100 * C, "cm100");
      run_meas(100, C - 1, "cm0");
      run_meas(100, C, "cm1");
      run_meas(20, 0, "noecho");
      run_meas(50, 430 * C, "sat");
      run_meas(50, MT, "meas_edge");
      run_meas(50, MT + 1, "meas_over");
      run_meas(50, MT + 500, "stuck");

      echo_pulse(200);
      repeat (10) tick();
      check_val("notrig_echo", q_cm.size(), 0);

      // second trig while measuring: ignored, result from the first echo
      pulse_trig();
      repeat (10) tick();
      echo = 1'b1;
      repeat (100) tick();
      pulse_trig();
      repeat (200) tick();
      echo = 1'b0;
      pop_result("retrig", ok, cm, ob, to, vc);
      if (ok) check_val("retrig_cm", cm, 302 / C);
      repeat (20) tick();
      check_val("retrig_extra", q_cm.size(), 0);

      // reset in the middle of a measurement
      pulse_trig();
      repeat (10) tick();
      echo = 1'b1;
      repeat (300) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_val("midrst_cm", int'(dist_cm), 0);
      check_val("midrst_valid", int'(dist_valid), 0);
      check_val("midrst_ob", int'(obstacle), 0);
      check_val("midrst_to", int'(timeout), 0);
      repeat (100) tick();
      echo = 1'b0;
      repeat (20) tick();
      check_val("midrst_nostrobe", q_cm.size(), 0);
      run_meas(50, 20 * C, "post_rst");

      for (int i = 0; i < 20; i++) begin
         sel = $urandom_range(0, 9);
         if (sel == 0)      n = 0;
         else if (sel == 1) n = MT - 1 + $urandom_range(0, 2);
         else if (sel == 2) n = (TH * C) - 1 + $urandom_range(0, 2);
         else               n = $urandom_range(1, 800);
         run_meas($urandom_range(0, 150), n, $sformatf("rnd%0d", i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
